apb_rr_master: RTL and testbench

Two-requester APB master that shares the single `AMBA_APB` slave between two internal clients. It arbitrates round-robin, sequences each transfer through the APB SETUP and ACCESS phases, and honours `P_ready` wait states. It returns read data and error status to the winning requester, and enforces an ACCESS-phase timeout so a hung slave cannot stall the bus.

---
 rtl/apb_rr_master.sv | 104 ++++++++++
 tb/tb_apb_rr_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// wait-state handling and an ACCESS-phase timeout against hung slaves.
module apb_rr_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                P_clk,
  input  logic                P_rst,
  input  logic [1:0]          rq_valid,
  input  logic [1:0]          rq_write,
  input  logic [2*ADDR_W-1:0] rq_addr,
  input  logic [2*DATA_W-1:0] rq_wdata,
  output logic [1:0]          rq_grant,
  output logic [1:0]          rq_done,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   P_addr,
  output logic                P_write,
  output logic [DATA_W-1:0]   P_wdata,
  output logic                P_selx,
  output logic                P_enable,
  input  logic                P_ready,
  input  logic                P_slverr,
  input  logic [DATA_W-1:0]   P_rdata
);

  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic          last;   // index of most recent grant
  logic          cur;    // requester owning the transfer in flight
  logic [CW-1:0] cnt;
  logic          win;

  // On a tie the requester that did not win last time goes next.
  always_comb win = (rq_valid == 2'b11) ? ~last : rq_valid[1];

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cur       <= 1'b0;
      cnt       <= '0;
      rq_grant  <= '0;
      rq_done   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      P_addr    <= '0;
      P_write   <= 1'b0;
      P_wdata   <= '0;
      P_selx    <= 1'b0;
      P_enable  <= 1'b0;
    end else begin
      rq_grant <= '0;
      rq_done  <= '0;
      case (state)
        IDLE: begin
          if (|rq_valid) begin
            cur           <= win;
            last          <= win;
            P_addr        <= win ? rq_addr[2*ADDR_W-1:ADDR_W]  : rq_addr[ADDR_W-1:0];
            P_wdata       <= win ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
            P_write       <= rq_write[win];
            rq_grant[win] <= 1'b1;
            P_selx        <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          P_enable <= 1'b1;
          cnt      <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (P_ready) begin
            rq_done[cur] <= 1'b1;
            rsp_err      <= P_slverr;
            rsp_rdata    <= P_write ? '0 : P_rdata;
            P_selx       <= 1'b0;
            P_enable     <= 1'b0;
            state        <= IDLE;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            // Abandon the slave; its state is unknown and no retry is made.
            rq_done[cur] <= 1'b1;
            rsp_err      <= 1'b1;
            rsp_rdata    <= '0;
            P_selx       <= 1'b0;
            P_enable     <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: vector table through a scoreboard, a memory-backed
// APB slave model, plus reset, contention and timeout sequences.
module tb_apb_rr_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          P_clk = 1'b0;
  logic          P_rst = 1'b1;
  logic [1:0]    rq_valid = '0;
  logic [1:0]    rq_write = '0;
  logic [2*AW-1:0] rq_addr = '0;
  logic [2*DW-1:0] rq_wdata = '0;
  logic [1:0]    rq_grant, rq_done;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] P_addr;
  logic          P_write;
  logic [DW-1:0] P_wdata;
  logic          P_selx, P_enable;
  logic          P_ready = 1'b0;
  logic          P_slverr = 1'b0;
  logic [DW-1:0] P_rdata = '0;

  apb_rr_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .P_clk(P_clk), .P_rst(P_rst),
    .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rq_grant(rq_grant), .rq_done(rq_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .P_addr(P_addr), .P_write(P_write), .P_wdata(P_wdata),
    .P_selx(P_selx), .P_enable(P_enable),
    .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata)
  );

  always #5 P_clk = ~P_clk;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          acc;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // APB slave model: small memory, programmable wait states and error
  int          cfg_waits = 0;
  bit          cfg_err = 0;
  int          acc_cnt = 0;
  logic [31:0] mem [16];

  always @(negedge P_clk) begin
    if (P_selx && P_enable) begin
      P_ready  = (acc_cnt >= cfg_waits);
      P_slverr = P_ready & cfg_err;
      P_rdata  = mem[P_addr[3:0]];
      if (P_ready && P_write) mem[P_addr[3:0]] = P_wdata;
      acc_cnt++;
    end else begin
      P_ready  = 1'b0;
      P_slverr = 1'b0;
      P_rdata  = 32'hBAD0_0000;
      acc_cnt  = 0;
    end
  end

  // Bus monitor and scoreboard consumer
  int          cyc = 0;
  always @(posedge P_clk) cyc <= cyc + 1;

  bit          in_x = 0;
  int          sel_n, en_n, low_run = 0, last_gap = 0;
  bit          stab;
  logic [31:0] snap_addr, snap_wd;
  logic        snap_wr;
  int          grant_cyc = 0, done_cyc = 0, done_n = 0;

  always @(negedge P_clk) begin
    exp_t e;
    if (P_selx) begin
      if (!in_x) begin
        in_x = 1; sel_n = 1; en_n = int'(P_enable); stab = 1;
        snap_addr = P_addr; snap_wr = P_write; snap_wd = P_wdata;
        last_gap = low_run;
      end else begin
        sel_n++;
        en_n += int'(P_enable);
        if (P_addr !== snap_addr || P_write !== snap_wr || P_wdata !== snap_wd) stab = 0;
      end
      low_run = 0;
    end else begin
      in_x = 0;
      low_run++;
    end
    if (|rq_grant) grant_cyc = cyc;
    if (|rq_done) begin
      done_cyc = cyc;
      done_n++;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_empty: got rq_done %b with nothing expected", rq_done);
      end else begin
        e = sb.pop_front();
        chk("done_idx", 64'(rq_done), 64'd1 << e.idx);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic do_xfer(input vec_t v);
    int  d0;
    bit  got;
    cfg_waits = v.waits;
    cfg_err   = v.err;
    sb.push_back('{v.idx, v.exp_rdata, v.exp_err});
    rq_write[v.idx]          = v.wr;
    rq_addr[v.idx*AW +: AW]  = v.addr;
    rq_wdata[v.idx*DW +: DW] = v.wdata;
    rq_valid[v.idx]          = 1'b1;
    d0  = done_n;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge P_clk); #1;
      if (rq_grant[v.idx]) got = 1;
    end
    rq_valid[v.idx] = 1'b0;
    chk("grant_seen", 64'(got), 64'd1);
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge P_clk); #1;
      if (done_n != d0) got = 1;
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(done_cyc - grant_cyc), 64'(v.acc + 1));
    chk("selx_cycles", 64'(sel_n), 64'(v.acc + 1));
    chk("enable_cycles", 64'(en_n), 64'(v.acc));
    chk("req_stable", 64'(stab), 64'd1);
    chk("p_addr", 64'(snap_addr), 64'(v.addr));
    chk("p_write", 64'(snap_wr), 64'(v.wr));
    if (v.wr) chk("p_wdata", 64'(snap_wd), 64'(v.wdata));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, 64'({P_selx, P_enable, P_write, rq_grant, rq_done, rsp_err}), 64'd0);
    chk({tag, "_addr"}, 64'(P_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(P_wdata), 64'd0);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    vec_t vr;
    int   d0, ng;
    bit   got;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0030 + i;
    //         idx wr addr  wdata         waits err exp_rdata     exp_err acc
    vt[0] = '{0, 1, 32'h1, 32'h7,        0,  0, 32'h0,        0, 1};
    vt[1] = '{1, 0, 32'h1, 32'h0,        0,  0, 32'h7,        0, 1};
    vt[2] = '{0, 1, 32'h2, 32'hA5A50001, 3,  0, 32'h0,        0, 4};
    vt[3] = '{1, 0, 32'h2, 32'h0,        0,  1, 32'hA5A50001, 1, 1};
    vt[4] = '{0, 0, 32'h3, 32'h0,        99, 0, 32'h0,        1, 4};
    vt[5] = '{1, 1, 32'h4, 32'hDEAD,     3,  0, 32'h0,        0, 4};
    vt[6] = '{1, 0, 32'h4, 32'h0,        0,  0, 32'hDEAD,     0, 1};

    repeat (3) @(negedge P_clk);
    #1;
    chk_outputs_zero("reset");
    P_rst = 1'b0;
    @(negedge P_clk); #1;

    for (int i = 0; i < 7; i++) do_xfer(vt[i]);

    repeat (3) @(negedge P_clk);
    #1;
    chk("rdata_hold", 64'(rsp_rdata), 64'hDEAD);

    // Reset while stuck in ACCESS: transfer dropped, no completion
    cfg_waits = 99; cfg_err = 0;
    rq_write[0] = 1'b0; rq_addr[AW-1:0] = 32'h5; rq_valid[0] = 1'b1;
    d0 = done_n; got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge P_clk); #1;
      if (rq_grant[0]) got = 1;
    end
    rq_valid[0] = 1'b0;
    chk("rst_grant_seen", 64'(got), 64'd1);
    repeat (3) @(negedge P_clk);
    #1;
    chk("pre_rst_access", 64'({P_selx, P_enable}), 64'b11);
    P_rst = 1'b1;
    @(negedge P_clk); #1;
    chk_outputs_zero("midrst");
    @(negedge P_clk); #1;
    P_rst = 1'b0;
    repeat (6) @(negedge P_clk);
    #1;
    chk("midrst_no_done", 64'(done_n), 64'(d0));
    vr = vt[1];
    do_xfer(vr);

    // Contention from reset: both requesters keep asking
    cfg_waits = 0; cfg_err = 0;
    rq_write = 2'b11;
    rq_addr  = {32'h11, 32'h10};
    rq_wdata = {32'h1111, 32'h1010};
    for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 32'h0, 1'b0});
    P_rst = 1'b1;
    rq_valid = 2'b11;
    repeat (2) @(negedge P_clk);
    #1;
    P_rst = 1'b0;
    d0 = done_n;
    ng = 0;
    for (int t = 0; t < 40 && ng < 4; t++) begin
      @(negedge P_clk); #1;
      rq_valid = 2'b11;
      if (|rq_grant) begin
        chk("rr_order", 64'(rq_grant), 64'd1 << (ng % 2));
        if (ng > 0) chk("rr_gap", 64'(last_gap), 64'd1);
        rq_valid = rq_valid & ~rq_grant;
        ng++;
      end
    end
    rq_valid = 2'b00;
    chk("rr_grants", 64'(ng), 64'd4);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge P_clk); #1;
      if (done_n == d0 + 4) got = 1;
    end
    chk("rr_dones", 64'(done_n - d0), 64'd4);
    chk("rr_wdata1", 64'(mem[1]), 64'h1111);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
